wb_stage: RTL and testbench

Write-back stage of the CPU pipeline, directly upstream of the general-purpose register file. Captures the MEM-stage result into a pipeline register, performs load-data alignment and sign/zero extension, and drives the register file's single write port. Also exports a forwarding copy of the pending write for the decode-stage hazard logic, a retired-instruction counter, and a misaligned-load flag for the exception logic.

---
 rtl/wb_stage_pkg.sv | 19 +
 rtl/wb_ld_align.sv | 49 ++++
 rtl/wb_stage.sv | 88 ++++++++
 tb/tb_wb_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared CPU definitions: bus widths, active-low enable levels, load-op codes.
// No logic; constants only.
// Imported by the write-back stage and its load aligner.
package wb_stage_pkg;
    localparam int REG_ADDR_W  = 5;
    localparam int WORD_DATA_W = 32;

    // Active-low enable levels used by the register-file write port.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Load kinds carried from MEM.
    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LW   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LHU  = 3'd3;
    localparam logic [2:0] LD_LB   = 3'd4;
    localparam logic [2:0] LD_LBU  = 3'd5;
endpackage

// File: rtl/wb_ld_align.sv
// Big-endian load aligner: picks word/half/byte from the raw read word and extends it.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module wb_ld_align
    import wb_stage_pkg::*;
(
    input  logic [WORD_DATA_W-1:0] i_rd_data,
    input  logic [1:0]             i_offset,
    input  logic [2:0]             i_ld_op,
    output logic [WORD_DATA_W-1:0] o_data,
    output logic                   o_misalign
);
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Offset 0 is the most significant byte/half of the bus word.
    always_comb begin
        w_half = i_offset[1] ? i_rd_data[15:0] : i_rd_data[31:16];
        case (i_offset)
            2'd0:    w_byte = i_rd_data[31:24];
            2'd1:    w_byte = i_rd_data[23:16];
            2'd2:    w_byte = i_rd_data[15:8];
            default: w_byte = i_rd_data[7:0];
        endcase
    end

    // Extension and alignment check per load kind; unknown codes give 0 and no fault.
    always_comb begin
        o_data     = '0;
        o_misalign = 1'b0;
        case (i_ld_op)
            LD_LW: begin
                o_data     = i_rd_data;
                o_misalign = (i_offset != 2'd0);
            end
            LD_LH: begin
                o_data     = {{16{w_half[15]}}, w_half};
                o_misalign = i_offset[0];
            end
            LD_LHU: begin
                o_data     = {16'h0000, w_half};
                o_misalign = i_offset[0];
            end
            LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  o_data = {24'h000000, w_byte};
            default: o_data = '0;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline register feeding the GPR write port, plus forwarding copy and retire counter.
// Latency: 1 cycle from MEM inputs to all outputs; every output is registered.
// Backpressure: stall holds every register (counter included); flush kills the captured instruction.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int R0_HARDWIRED = 0,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   mem_en,
    input  logic                   mem_gpr_we_,
    input  logic [REG_ADDR_W-1:0]  mem_dst_addr,
    input  logic [WORD_DATA_W-1:0] mem_out,
    input  logic [2:0]             mem_ld_op,
    input  logic [WORD_DATA_W-1:0] mem_rd_data,
    output logic                   gpr_we_,
    output logic [REG_ADDR_W-1:0]  gpr_wr_addr,
    output logic [WORD_DATA_W-1:0] gpr_wr_data,
    output logic                   fwd_en,
    output logic [REG_ADDR_W-1:0]  fwd_addr,
    output logic [WORD_DATA_W-1:0] fwd_data,
    output logic                   wb_misalign,
    output logic [CNT_W-1:0]       retired_cnt
);
    logic                   r_we_;
    logic [REG_ADDR_W-1:0]  r_addr;
    logic [WORD_DATA_W-1:0] r_data;
    logic                   r_misalign;
    logic [CNT_W-1:0]       r_cnt;

    logic [WORD_DATA_W-1:0] w_ld_data;
    logic                   w_ld_misalign;
    logic [WORD_DATA_W-1:0] w_result;
    logic                   w_r0_block;
    logic                   w_write_ok;

    wb_ld_align u_align (
        .i_rd_data  (mem_rd_data),
        .i_offset   (mem_out[1:0]),
        .i_ld_op    (mem_ld_op),
        .o_data     (w_ld_data),
        .o_misalign (w_ld_misalign)
    );

    // Result selection and write qualification for the instruction being captured.
    always_comb begin
        w_result   = (mem_ld_op == LD_NONE) ? mem_out : w_ld_data;
        w_r0_block = (R0_HARDWIRED != 0) && (mem_dst_addr == '0);
        w_write_ok = mem_en && (mem_gpr_we_ == ENABLE_) && !w_ld_misalign && !w_r0_block;
    end

    // Pipeline register and counter: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_we_      <= DISABLE_;
            r_addr     <= '0;
            r_data     <= '0;
            r_misalign <= 1'b0;
            r_cnt      <= '0;
        end else if (flush) begin
            r_we_      <= DISABLE_;
            r_addr     <= '0;
            r_data     <= '0;
            r_misalign <= 1'b0;
        end else if (!stall) begin
            r_we_      <= w_write_ok ? ENABLE_ : DISABLE_;
            r_addr     <= mem_dst_addr;
            r_data     <= w_result;
            r_misalign <= mem_en && w_ld_misalign;
            if (mem_en) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign gpr_we_     = r_we_;
    assign gpr_wr_addr = r_addr;
    assign gpr_wr_data = r_data;
    assign fwd_en      = (r_we_ == ENABLE_);
    assign fwd_addr    = r_addr;
    assign fwd_data    = r_data;
    assign wb_misalign = r_misalign;
    assign retired_cnt = r_cnt;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, hand sequences, randomized run against a reference model.
// Two instances share stimulus: default parameters, and R0_HARDWIRED=1 with a 4-bit counter.
// Outputs are sampled 1 time unit after the rising edge.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush, mem_en, mem_gpr_we_;
    logic [4:0]  mem_dst_addr;
    logic [31:0] mem_out, mem_rd_data;
    logic [2:0]  mem_ld_op;

    logic        d0_we_, d0_fwd_en, d0_mis;
    logic [4:0]  d0_addr, d0_fwd_addr;
    logic [31:0] d0_data, d0_fwd_data, d0_cnt;
    logic        d1_we_, d1_fwd_en, d1_mis;
    logic [4:0]  d1_addr, d1_fwd_addr;
    logic [31:0] d1_data, d1_fwd_data;
    logic [3:0]  d1_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_stage #(.R0_HARDWIRED(0), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .mem_en(mem_en),
        .mem_gpr_we_(mem_gpr_we_), .mem_dst_addr(mem_dst_addr), .mem_out(mem_out),
        .mem_ld_op(mem_ld_op), .mem_rd_data(mem_rd_data),
        .gpr_we_(d0_we_), .gpr_wr_addr(d0_addr), .gpr_wr_data(d0_data),
        .fwd_en(d0_fwd_en), .fwd_addr(d0_fwd_addr), .fwd_data(d0_fwd_data),
        .wb_misalign(d0_mis), .retired_cnt(d0_cnt)
    );

    wb_stage #(.R0_HARDWIRED(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .mem_en(mem_en),
        .mem_gpr_we_(mem_gpr_we_), .mem_dst_addr(mem_dst_addr), .mem_out(mem_out),
        .mem_ld_op(mem_ld_op), .mem_rd_data(mem_rd_data),
        .gpr_we_(d1_we_), .gpr_wr_addr(d1_addr), .gpr_wr_data(d1_data),
        .fwd_en(d1_fwd_en), .fwd_addr(d1_fwd_addr), .fwd_data(d1_fwd_data),
        .wb_misalign(d1_mis), .retired_cnt(d1_cnt)
    );

    typedef struct {
        logic        en;
        logic        we_n;
        logic [4:0]  dst;
        logic [31:0] out;
        logic [2:0]  op;
        logic [31:0] rd;
        logic        x_we_n;
        logic [31:0] x_data;
        logic        x_mis;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic we_n, input logic [4:0] dst,
                         input logic [31:0] out, input logic [2:0] op, input logic [31:0] rd);
        mem_en = en; mem_gpr_we_ = we_n; mem_dst_addr = dst;
        mem_out = out; mem_ld_op = op; mem_rd_data = rd;
    endtask

    function automatic vec_t mk(input logic en, input logic we_n, input logic [4:0] dst,
                                input logic [31:0] out, input logic [2:0] op, input logic [31:0] rd,
                                input logic x_we_n, input logic [31:0] x_data, input logic x_mis);
        vec_t v;
        v.en = en; v.we_n = we_n; v.dst = dst; v.out = out; v.op = op; v.rd = rd;
        v.x_we_n = x_we_n; v.x_data = x_data; v.x_mis = x_mis;
        return v;
    endfunction

    // Reference: what a load of the given kind returns, from byte-lane arithmetic.
    function automatic void ref_load(input logic [2:0] op, input logic [31:0] out, input logic [31:0] rd,
                                     output logic [31:0] val, output logic mis);
        int off;
        logic [31:0] lane;
        off  = int'(out[1:0]);
        val  = 32'h0;
        mis  = 1'b0;
        case (op)
            3'd0: val = out;
            3'd1: begin val = rd; mis = (off != 0); end
            3'd2, 3'd3: begin
                lane = (rd >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
                if (op == 3'd2 && lane >= 32'h8000) val = lane | 32'hFFFF_0000;
                else val = lane;
                mis = (off % 2) != 0;
            end
            3'd4, 3'd5: begin
                lane = (rd >> (8 * (3 - off))) & 32'hFF;
                if (op == 3'd4 && lane >= 32'h80) val = lane | 32'hFFFF_FF00;
                else val = lane;
            end
            default: val = 32'h0;
        endcase
    endfunction

    vec_t tv[14];
    int   n_en;
    logic [31:0] held_data, held_cnt;

    logic        m_we_n, m_mis, m1_we_n;
    logic [4:0]  m_addr;
    logic [31:0] m_data, m_cnt0;
    logic [3:0]  m_cnt1;

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b1, 5'd0, 32'h0, 3'd0, 32'h0);

        // Reset held for two cycles.
        cyc(); cyc();
        chk("rst_we", {31'h0, d0_we_}, 32'h1);
        chk("rst_data", d0_data, 32'h0);
        chk("rst_cnt", d0_cnt, 32'h0);
        chk("rst_mis", {31'h0, d0_mis}, 32'h0);
        chk("rst_cnt1", {28'h0, d1_cnt}, 32'h0);
        reset = 1'b1;

        // Directed vectors, one instruction per cycle.
        tv[0]  = mk(1, 0, 5'd5,  32'h1234_5678, 3'd0, 32'h0,         0, 32'h1234_5678, 0);
        tv[1]  = mk(1, 0, 5'd1,  32'h0000_0100, 3'd4, 32'h80FF_7F01, 0, 32'hFFFF_FF80, 0);
        tv[2]  = mk(1, 0, 5'd2,  32'h0000_0101, 3'd5, 32'h80FF_7F01, 0, 32'h0000_00FF, 0);
        tv[3]  = mk(1, 0, 5'd3,  32'h0000_0102, 3'd2, 32'h80FF_7F01, 0, 32'h0000_7F01, 0);
        tv[4]  = mk(1, 0, 5'd4,  32'h0000_0100, 3'd3, 32'h80FF_7F01, 0, 32'h0000_80FF, 0);
        tv[5]  = mk(1, 0, 5'd6,  32'h0000_0102, 3'd1, 32'h80FF_7F01, 1, 32'h0,         1);
        tv[6]  = mk(1, 0, 5'd7,  32'h0000_0200, 3'd1, 32'h80FF_7F01, 0, 32'h80FF_7F01, 0);
        tv[7]  = mk(1, 0, 5'd8,  32'h0000_0203, 3'd4, 32'h80FF_7F01, 0, 32'h0000_0001, 0);
        tv[8]  = mk(1, 0, 5'd9,  32'h0000_0202, 3'd5, 32'h80FF_7F01, 0, 32'h0000_007F, 0);
        tv[9]  = mk(1, 0, 5'd10, 32'h0000_0200, 3'd2, 32'h80FF_7F01, 0, 32'hFFFF_80FF, 0);
        tv[10] = mk(1, 1, 5'd11, 32'hDEAD_BEEF, 3'd0, 32'h0,         1, 32'h0,         0);
        tv[11] = mk(0, 0, 5'd12, 32'hDEAD_BEEF, 3'd0, 32'h0,         1, 32'h0,         0);
        tv[12] = mk(1, 0, 5'd13, 32'h0000_0301, 3'd3, 32'h80FF_7F01, 1, 32'h0,         1);
        tv[13] = mk(1, 0, 5'd0,  32'h0000_00AA, 3'd0, 32'h0,         0, 32'h0000_00AA, 0);
        n_en = 0;
        for (int i = 0; i < 14; i++) begin
            drive(tv[i].en, tv[i].we_n, tv[i].dst, tv[i].out, tv[i].op, tv[i].rd);
            if (tv[i].en) n_en++;
            cyc();
            chk($sformatf("tv%0d_we", i), {31'h0, d0_we_}, {31'h0, tv[i].x_we_n});
            chk($sformatf("tv%0d_mis", i), {31'h0, d0_mis}, {31'h0, tv[i].x_mis});
            if (!tv[i].x_we_n) begin
                chk($sformatf("tv%0d_addr", i), {27'h0, d0_addr}, {27'h0, tv[i].dst});
                chk($sformatf("tv%0d_data", i), d0_data, tv[i].x_data);
                chk($sformatf("tv%0d_fwd", i), {d0_fwd_en, 26'h0, d0_fwd_addr}, {1'b1, 26'h0, tv[i].dst});
                chk($sformatf("tv%0d_fwdd", i), d0_fwd_data, tv[i].x_data);
            end
            if (i == 0) chk("alu_cnt", d0_cnt, 32'h1);
        end
        chk("tv_cnt", d0_cnt, n_en);
        // R0 write: suppressed only in the hardwired instance.
        chk("r0_we_hw", {31'h0, d1_we_}, 32'h1);

        // Write pending, then stall 3 cycles with different inputs.
        drive(1, 0, 5'd7, 32'hCAFE_BABC, 3'd0, 32'h0);
        cyc();
        held_data = d0_data;
        held_cnt  = d0_cnt;
        chk("pre_stall_data", held_data, 32'hCAFE_BABC);
        stall = 1'b1;
        drive(1, 0, 5'd9, 32'h1111_1111, 3'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("stall%0d_we", i), {31'h0, d0_we_}, 32'h0);
            chk($sformatf("stall%0d_data", i), d0_data, 32'hCAFE_BABC);
            chk($sformatf("stall%0d_addr", i), {27'h0, d0_addr}, 32'd7);
            chk($sformatf("stall%0d_cnt", i), d0_cnt, held_cnt);
        end
        // Stall and flush together: flush wins, counter unchanged.
        flush = 1'b1;
        cyc();
        chk("sf_we", {31'h0, d0_we_}, 32'h1);
        chk("sf_fwd", {31'h0, d0_fwd_en}, 32'h0);
        chk("sf_cnt", d0_cnt, held_cnt);
        flush = 1'b0;
        // Reset during stall clears the counter.
        reset = 1'b0;
        cyc();
        chk("rst_stall_cnt", d0_cnt, 32'h0);
        chk("rst_stall_we", {31'h0, d0_we_}, 32'h1);
        reset = 1'b1;
        stall = 1'b0;

        // Counter wrap on the 4-bit instance.
        drive(1, 1, 5'd3, 32'h0, 3'd0, 32'h0);
        for (int i = 0; i < 15; i++) cyc();
        chk("wrap15", {28'h0, d1_cnt}, 32'd15);
        cyc();
        chk("wrap0", {28'h0, d1_cnt}, 32'd0);
        chk("nowrap32", d0_cnt, 32'd16);

        // Randomized run against the reference model, starting from a reset.
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        cyc();
        m_we_n = 1; m1_we_n = 1; m_mis = 0; m_addr = 0; m_data = 0; m_cnt0 = 0; m_cnt1 = 0;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] val;
            logic mis;
            reset = ($urandom_range(0, 39) != 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                  $urandom, 3'($urandom_range(0, 5)), $urandom);
            ref_load(mem_ld_op, mem_out, mem_rd_data, val, mis);
            if (!reset) begin
                m_we_n = 1; m1_we_n = 1; m_mis = 0; m_cnt0 = 0; m_cnt1 = 0;
            end else if (flush) begin
                m_we_n = 1; m1_we_n = 1; m_mis = 0;
            end else if (!stall) begin
                m_we_n  = !(mem_en && !mem_gpr_we_ && !mis);
                m1_we_n = m_we_n || (mem_dst_addr == 5'd0);
                m_mis   = mem_en && mis;
                m_addr  = mem_dst_addr;
                m_data  = val;
                if (mem_en) begin
                    m_cnt0 = m_cnt0 + 1;
                    m_cnt1 = m_cnt1 + 1;
                end
            end
            cyc();
            chk("rnd_we", {31'h0, d0_we_}, {31'h0, m_we_n});
            chk("rnd_mis", {31'h0, d0_mis}, {31'h0, m_mis});
            chk("rnd_cnt", d0_cnt, m_cnt0);
            chk("rnd_we1", {31'h0, d1_we_}, {31'h0, m1_we_n});
            chk("rnd_cnt1", {28'h0, d1_cnt}, {28'h0, m_cnt1});
            if (!m_we_n) begin
                chk("rnd_addr", {27'h0, d0_addr}, {27'h0, m_addr});
                chk("rnd_data", d0_data, m_data);
                chk("rnd_fwd", {31'h0, d0_fwd_en}, 32'h1);
                chk("rnd_fwdd", d0_fwd_data, m_data);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
